lag_pl_pipelined_allocator: RTL and testbench
=============================================

# lag_pl_pipelined_allocator

Two-stage, pipelined physical-link (PL) allocator for the LAG router: assigns a free output PL, on the requested output port, to each packet head waiting on an input PL. Unlike the single-cycle unrestricted allocator, it owns the PL busy state, honours a per-packet PL mask, and uses age-based priority so a losing requester cannot starve. It sits between the input-PL head-flit decode logic and the switch allocator.

## Interface
- `np`, 5, number of router ports.
- `nl`, 2, PLs per port, uniform on inputs and outputs.
- `age_bits`, 3, width of the per-requester age counter.
- `age_thresh`, 4, age value at or above which a request is high priority; range 1..2^age_bits-1.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req`  in  [np][nl]  input PL requests a new output PL; level, held until granted or abandoned.
- `output_port`  in  [np][nl][np]  one-hot destination port per requester; stable while `req` is high.
- `pl_mask`  in  [np][nl][nl]  PLs this packet may use; all-zero means the request is never served.
- `pl_release`  in  [np][nl]  one-cycle pulse; frees output PL [port][pl] (tail flit departed).
- `pl_new`  out  [np][nl][nl]  one-hot granted output PL index per requester.
- `pl_new_valid`  out  [np][nl]  one-cycle grant pulse per requester.
- `pl_allocated`  out  [np][nl]  one-cycle pulse per output PL on the edge it becomes busy.
- `pl_busy`  out  [np][nl]  registered busy status per output PL.

## Operation
- State: `busy[np][nl]`; stage-1 register `s1_valid`/`s1_pl` (one-hot)/`s1_port` per requester; `age[np][nl]`; one round-robin pointer per requester (stage 1) and per output PL (stage 2).
- Stage 1 (PL selection): a requester with `req=1` and `s1_valid=0` forms candidates = `pl_mask & ~busy[port]`. Round-robin picks one candidate, starting after that requester's last pick; the result is registered with `s1_valid=1`. With no candidates, nothing is registered and selection is retried next cycle.
- Stage 2 (PL arbitration): each output PL [c][d] receives requests from every `s1_valid` entry with `s1_port=c` and `s1_pl=d`, provided `req` is still high.
  - If any of those requesters has `age>=age_thresh`, only those requesters compete.
  - Otherwise all requesters compete.
  - Round-robin over the flattened np*nl index picks one winner. The pointer advances past the winner only on a grant.
- Grant (registered): winner gets `pl_new_valid=1` and `pl_new` = one-hot d. `busy[c][d]` sets, `pl_allocated[c][d]` pulses, and the winner's age clears.
- Loser: its age increments (saturating at 2^age_bits-1). Every evaluated stage-1 entry clears `s1_valid`, whether it won or lost, so a loser reselects.
- Abandon: when `req` drops, the stage-1 entry is dropped without a grant and age clears.
- Requester handshake: deassert `req` on or before the cycle after `pl_new_valid`. A `req` still high then is treated as a new packet.
- Release: `pl_release` on a busy PL clears it. Release on a non-busy PL is ignored.
- Release and grant on the same PL in the same edge cannot occur, because stage 1 excluded that PL as busy.
- Invariant: at most one grant per output PL per cycle, and at most one per requester per two cycles.

## Timing
- Reset: all outputs 0; busy, s1_valid and age cleared; pointers reset to index 0. Reset asserted mid-allocation discards every pending selection and frees every PL.
- Latency, uncontended: `req` sampled high at edge k → stage-1 registered at k → `pl_new_valid`, `pl_allocated` and `pl_busy` high after edge k+1.
- A loser at edge k+1 reselects at edge k+2 and can be granted at edge k+3.
- Release at edge r: `pl_busy` low after r. Stage 1 can select that PL at r+1, giving a grant at r+2.
- Stage 1 reads registered `busy` only; it never sees same-cycle grants. A collision therefore resolves in stage 2 and costs 2 cycles.
- Age saturates; it never wraps.

## Test plan
- Single request: np=5, nl=2; req[0][0]=1, output_port=port 2, mask=2'b11, all free. Required: grant 2 edges later with pl_new[0][0]=2'b01; pl_allocated[2][0] and pl_busy[2][0]=1.
- Collision: req[0][0] and req[1][0], both to port 2, mask=2'b01. Required: one requester is granted at k+1; the other's age=1, it finds no candidate, and it is granted 2 cycles after pl_release[2][0].
- Full port: both PLs of port 3 busy; req[4][1] to port 3. Required: no grant while busy. Release PL1 at edge r → grant at r+2 with pl_new=2'b10.
- Aging: age_thresh=2; requesters A and B contend for one PL. After A loses twice and the PL is released, A wins over B even with the pointer favouring B.
- Abandon/reset: req drops the cycle after stage 1 → no grant, no busy, age=0. rst_n low mid-allocation → all outputs 0 asynchronously; pl_busy all 0 after release of reset.
- Mask: mask=2'b10 with PL1 busy and PL0 free → no grant until PL1 is released.

Source files
------------

// File: rtl/lag_pl_pipelined_allocator.sv
// lag_pl_pipelined_allocator: two-stage age-prioritised output-PL allocator that owns the PL busy state
// Ports are flattened, requester r = in_port*nl + in_pl and output PL o = out_port*nl + out_pl:
//   req[r], pl_release[o], pl_new_valid[r], pl_allocated[o], pl_busy[o]  one bit each
//   output_port[r*np +: np]  one-hot destination port
//   pl_mask[r*nl +: nl]      allowed output PLs
//   pl_new[r*nl +: nl]       one-hot granted output PL
module lag_pl_pipelined_allocator #(
  parameter int np = 5,
  parameter int nl = 2,
  parameter int age_bits = 3,
  parameter int age_thresh = 4
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [np*nl-1:0]      req,
  input  logic [np*nl*np-1:0]   output_port,
  input  logic [np*nl*nl-1:0]   pl_mask,
  input  logic [np*nl-1:0]      pl_release,
  output logic [np*nl*nl-1:0]   pl_new,
  output logic [np*nl-1:0]      pl_new_valid,
  output logic [np*nl-1:0]      pl_allocated,
  output logic [np*nl-1:0]      pl_busy
);
  localparam int nr = np * nl;
  localparam int pw = np > 1 ? $clog2(np) : 1;
  localparam int lw = nl > 1 ? $clog2(nl) : 1;
  localparam int rw = nr > 1 ? $clog2(nr) : 1;
  logic [nr-1:0]       busy, s1_valid, sel, aged, hit, g;
  logic [nl-1:0]       s1_pl [nr];
  logic [pw-1:0]       s1_port [nr];
  logic [age_bits-1:0] age [nr];
  logic [lw-1:0]       ptr1 [nr];
  logic [rw-1:0]       ptr2 [nr];
  logic [pw-1:0]       port_idx [nr];
  logic [nl-1:0]       cand [nr];
  logic [lw-1:0]       pick [nr];
  logic [nr-1:0]       rq [nr];
  logic [nr-1:0]       comp [nr];
  logic [rw-1:0]       win [nr];
  assign pl_busy = busy;
  // Stage 1: per-requester PL selection against registered busy state.
  // A requester whose grant is being presented this cycle is not reselected,
  // so a req held through the grant cycle does not start a second allocation.
  always_comb begin
    for (int r = 0; r < nr; r++) begin
      port_idx[r] = '0;
      for (int p = 0; p < np; p++)
        if (output_port[r*np+p]) port_idx[r] = pw'(p);
      cand[r] = pl_mask[r*nl +: nl] & ~busy[int'(port_idx[r])*nl +: nl];
      pick[r] = '0;
      for (int k = nl - 1; k >= 0; k--)
        if (cand[r][(int'(ptr1[r]) + k) % nl]) pick[r] = lw'((int'(ptr1[r]) + k) % nl);
      sel[r] = req[r] & ~s1_valid[r] & ~pl_new_valid[r] & (|cand[r]);
      aged[r] = age[r] >= age_bits'(age_thresh);
    end
  end
  // Stage 2: per-output-PL arbitration; aged requesters mask out young ones.
  // A PL granted on the same edge its stage-1 selection was made is busy by now,
  // so busy gates the request and the late selector simply loses.
  always_comb begin
    g = '0;
    for (int o = 0; o < nr; o++) begin
      for (int r = 0; r < nr; r++)
        rq[o][r] = s1_valid[r] & req[r] & ~busy[o] & (int'(s1_port[r]) == o / nl) & s1_pl[r][o % nl];
      comp[o] = |(rq[o] & aged) ? rq[o] & aged : rq[o];
      win[o] = '0;
      for (int k = nr - 1; k >= 0; k--)
        if (comp[o][(int'(ptr2[o]) + k) % nr]) win[o] = rw'((int'(ptr2[o]) + k) % nr);
      hit[o] = |comp[o];
      if (hit[o]) g[win[o]] = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      s1_valid <= '0;
      pl_new <= '0;
      pl_new_valid <= '0;
      pl_allocated <= '0;
      for (int r = 0; r < nr; r++) begin
        s1_pl[r] <= '0;
        s1_port[r] <= '0;
        age[r] <= '0;
        ptr1[r] <= '0;
        ptr2[r] <= '0;
      end
    end else begin
      busy <= (busy & ~pl_release) | hit;
      pl_allocated <= hit;
      pl_new_valid <= g;
      s1_valid <= sel;
      for (int r = 0; r < nr; r++) begin
        pl_new[r*nl +: nl] <= g[r] ? s1_pl[r] : '0;
        if (sel[r]) begin
          s1_pl[r] <= nl'(1) << pick[r];
          s1_port[r] <= port_idx[r];
          ptr1[r] <= lw'((int'(pick[r]) + 1) % nl);
        end
        age[r] <= (!req[r] || g[r]) ? '0 : (s1_valid[r] && !(&age[r])) ? age[r] + 1'b1 : age[r];
        if (hit[r]) ptr2[r] <= rw'((int'(win[r]) + 1) % nr);
      end
    end
  end
endmodule

// File: tb/tb_lag_pl_pipelined_allocator.sv
// tb_lag_pl_pipelined_allocator: directed self-checking bench for the pipelined PL allocator
module tb_lag_pl_pipelined_allocator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  req = '0;
  logic [49:0] output_port = '0;
  logic [19:0] pl_mask = '0;
  logic [9:0]  pl_release = '0;
  logic [19:0] pl_new;
  logic [9:0]  pl_new_valid, pl_allocated, pl_busy;
  int n_checks = 0;
  int n_fail = 0;
  lag_pl_pipelined_allocator #(.np(5), .nl(2), .age_bits(3), .age_thresh(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .output_port(output_port), .pl_mask(pl_mask),
    .pl_release(pl_release), .pl_new(pl_new), .pl_new_valid(pl_new_valid),
    .pl_allocated(pl_allocated), .pl_busy(pl_busy)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int r, input int p, input logic [1:0] m);
    req[r] = 1'b1;
    output_port[r*5 +: 5] = 5'b00001 << p;
    pl_mask[r*2 +: 2] = m;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic release_pl(input int o);
    pl_release[o] = 1'b1;
    tick();
    pl_release[o] = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    chk("rst_busy", 32'(pl_busy), 32'h0);
    chk("rst_valid", 32'(pl_new_valid), 32'h0);
    chk("rst_new", 32'(pl_new), 32'h0);
    chk("rst_alloc", 32'(pl_allocated), 32'h0);
    rst_n = 1'b1;
    tick();
    // single request: r0 -> port 2, both PLs free, picks PL0 (o4)
    set_req(0, 2, 2'b11);
    tick();
    chk("single_k", 32'(pl_new_valid), 32'h0);
    tick();
    chk("single_valid", 32'(pl_new_valid), 32'h001);
    chk("single_new", 32'(pl_new), 32'h00001);
    chk("single_alloc", 32'(pl_allocated), 32'h010);
    chk("single_busy", 32'(pl_busy), 32'h010);
    req[0] = 1'b0;
    tick();
    chk("single_pulse", 32'(pl_new_valid | pl_allocated), 32'h0);
    chk("single_hold", 32'(pl_busy), 32'h010);
    release_pl(4);
    chk("single_rel", 32'(pl_busy), 32'h0);
    // collision: r0 and r2 on PL o4; pointer of o4 sits at 1, so r2 wins
    set_req(0, 2, 2'b01);
    set_req(2, 2, 2'b01);
    tick();
    tick();
    chk("coll_win", 32'(pl_new_valid), 32'h004);
    chk("coll_new", 32'(pl_new), 32'h00010);
    req[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("coll_wait", 32'(pl_new_valid), 32'h0);
    end
    release_pl(4);
    chk("coll_rel", 32'(pl_busy), 32'h0);
    tick();
    chk("coll_r1", 32'(pl_new_valid), 32'h0);
    tick();
    chk("coll_r2", 32'(pl_new_valid), 32'h001);
    chk("coll_r2_new", 32'(pl_new), 32'h00001);
    chk("coll_r2_busy", 32'(pl_busy), 32'h010);
    req[0] = 1'b0;
    tick();
    release_pl(4);
    // full port: fill port 3 (o6, o7), then r9 waits for PL1
    set_req(5, 3, 2'b11);
    tick();
    tick();
    chk("full_a", 32'(pl_new_valid), 32'h020);
    chk("full_a_new", 32'(pl_new), 32'h00400);
    req[5] = 1'b0;
    set_req(6, 3, 2'b11);
    tick();
    tick();
    chk("full_b", 32'(pl_new_valid), 32'h040);
    chk("full_b_new", 32'(pl_new), 32'h02000);
    chk("full_busy", 32'(pl_busy), 32'h0C0);
    req[6] = 1'b0;
    set_req(9, 3, 2'b11);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_wait", 32'(pl_new_valid), 32'h0);
    end
    release_pl(7);
    chk("full_rel", 32'(pl_busy), 32'h040);
    tick();
    chk("full_r1", 32'(pl_new_valid), 32'h0);
    tick();
    chk("full_r2", 32'(pl_new_valid), 32'h200);
    chk("full_r2_new", 32'(pl_new), 32'h80000);
    chk("full_r2_alloc", 32'(pl_allocated), 32'h080);
    chk("full_r2_busy", 32'(pl_busy), 32'h0C0);
    req[9] = 1'b0;
    tick();
    // mask: r3 may only use PL1 of port 0, which r1 holds
    set_req(1, 0, 2'b10);
    tick();
    tick();
    chk("mask_a", 32'(pl_new_valid), 32'h002);
    chk("mask_a_new", 32'(pl_new), 32'h00008);
    req[1] = 1'b0;
    set_req(3, 0, 2'b10);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mask_wait", 32'(pl_new_valid), 32'h0);
      chk("mask_busy", 32'(pl_busy), 32'h0C2);
    end
    release_pl(1);
    tick();
    tick();
    chk("mask_grant", 32'(pl_new_valid), 32'h008);
    chk("mask_new", 32'(pl_new), 32'h00080);
    req[3] = 1'b0;
    tick();
    // aging on o8: A=r9 loses to r1 and r2, then beats r3 despite pointer at 3
    set_req(9, 4, 2'b01);
    set_req(1, 4, 2'b01);
    tick();
    tick();
    chk("age_c1", 32'(pl_new_valid), 32'h002);
    req[1] = 1'b0;
    set_req(2, 4, 2'b01);
    release_pl(8);
    chk("age_rel1", 32'(pl_busy), 32'h0C2);
    tick();
    tick();
    chk("age_c2", 32'(pl_new_valid), 32'h004);
    req[2] = 1'b0;
    set_req(3, 4, 2'b01);
    release_pl(8);
    tick();
    tick();
    chk("age_c3", 32'(pl_new_valid), 32'h200);
    chk("age_c3_new", 32'(pl_new), 32'h40000);
    req[9] = 1'b0;
    req[3] = 1'b0;
    tick();
    // abandon: r0 drops req right after stage 1
    set_req(0, 1, 2'b01);
    tick();
    req[0] = 1'b0;
    tick();
    chk("abn_valid", 32'(pl_new_valid | pl_allocated), 32'h0);
    chk("abn_busy", 32'(pl_busy), 32'h1C2);
    tick();
    chk("abn_late", 32'(pl_new_valid), 32'h0);
    // reset mid-allocation: r0 granted o2 while r4 holds a pending selection of o3
    set_req(0, 1, 2'b01);
    tick();
    set_req(4, 1, 2'b10);
    tick();
    chk("rstm_valid", 32'(pl_new_valid), 32'h001);
    chk("rstm_busy", 32'(pl_busy), 32'h1C6);
    #1 rst_n = 1'b0;
    #1;
    chk("rstm_async_busy", 32'(pl_busy), 32'h0);
    chk("rstm_async_out", 32'(pl_new_valid | pl_allocated), 32'h0);
    chk("rstm_async_new", 32'(pl_new), 32'h0);
    req = '0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("rstm_after_busy", 32'(pl_busy), 32'h0);
    chk("rstm_after_valid", 32'(pl_new_valid), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
